// File: rtl/barrel_shift_sequencer.sv
// Sequential 16-bit barrel shifter front end. One shift stage (8/4/2/1) is applied per clock,
// MSB stage first. Operands and results move over valid/ready handshakes.
module barrel_shift_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic                       in_dir,
    input  logic                       in_arith,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH)-1:0]   stage_en,
    output logic                       busy
);

    localparam int STAGES = $clog2(WIDTH);
    localparam logic [STAGES-1:0] STAGE_MSB = STAGES'(1) << (STAGES - 1);
    localparam logic [WIDTH-1:0]  ALL_ONES  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    work_q;
    logic [WIDTH-1:0]    work_d;
    logic [STAGES-1:0]   shamt_q;
    logic                dir_q;
    logic                arith_q;
    logic                sign_q;
    logic [STAGES-1:0]   stage_en_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic                busy_q;

    logic                stepActive;
    logic [WIDTH-1:0]    shiftedLeft;
    logic [WIDTH-1:0]    shiftedRight;
    logic [WIDTH-1:0]    fillMask;

    // The one-hot stage enable doubles as the shift distance of the current stage (2^k).
    always_comb begin
        stepActive   = |(shamt_q & stage_en_q);
        shiftedLeft  = work_q << stage_en_q;
        shiftedRight = work_q >> stage_en_q;
        fillMask     = ~(ALL_ONES >> stage_en_q);
        work_d       = work_q;
        if (stepActive) begin
            if (!dir_q) begin
                work_d = shiftedLeft;
            end else if (arith_q && sign_q) begin
                work_d = shiftedRight | fillMask;
            end else begin
                work_d = shiftedRight;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            shamt_q     <= '0;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
            sign_q      <= 1'b0;
            stage_en_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= SHIFT;
                        work_q     <= in_data;
                        shamt_q    <= in_shamt;
                        dir_q      <= in_dir;
                        arith_q    <= in_arith;
                        sign_q     <= in_data[WIDTH-1];
                        stage_en_q <= STAGE_MSB;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    if (stage_en_q[0]) begin
                        state_q     <= DONE;
                        stage_en_q  <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= work_d;
                    end else begin
                        stage_en_q <= stage_en_q >> 1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign stage_en  = stage_en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Self-checking bench for barrel_shift_sequencer: directed vector table, backpressure,
// mid-operation reset and randomized operations against an arithmetic reference model.
module tb_barrel_shift_sequencer;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [STAGES-1:0]  in_shamt;
    logic               in_dir;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [STAGES-1:0]  stage_en;
    logic               busy;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        logic [WIDTH-1:0]  data;
        logic [STAGES-1:0] shamt;
        logic              dir;
        logic              arith;
        logic [WIDTH-1:0]  expected;
        int                holdCycles;
        string             name;
    } vec_t;

    vec_t vecs[8];

    barrel_shift_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stage_en  (stage_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Whole-word shift by the full amount, independent of any staging.
    function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] data, input logic [STAGES-1:0] shamt,
                                                  input logic dir, input logic arith);
        logic [WIDTH-1:0] result;
        if (!dir) begin
            result = data << shamt;
        end else if (arith) begin
            result = $signed(data) >>> shamt;
        end else begin
            result = data >> shamt;
        end
        return result;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic [STAGES-1:0] shamt,
                                 input logic dir, input logic arith, input logic [WIDTH-1:0] expected,
                                 input int holdCycles, input bit readyEarly, input string name);
        @(negedge clk);
        checkOutput({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_shamt = shamt;
        in_dir   = dir;
        in_arith = arith;
        @(posedge clk);
        #1;
        in_valid  = (holdCycles > 0);
        in_data   = WIDTH'($urandom);
        in_shamt  = STAGES'($urandom);
        in_dir    = 1'($urandom);
        in_arith  = 1'($urandom);
        out_ready = readyEarly;
        for (int i = 0; i < STAGES; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s stage_en[%0d]", name, i), 32'(stage_en), 32'(1 << (STAGES - 1 - i)));
            checkOutput($sformatf("%s out_valid shift[%0d]", name, i), 32'(out_valid), 32'd0);
            checkOutput($sformatf("%s busy shift[%0d]", name, i), 32'(busy), 32'd1);
            checkOutput($sformatf("%s in_ready shift[%0d]", name, i), 32'(in_ready), 32'd0);
            if (i == STAGES - 1) out_ready = 1'b0;
        end
        @(negedge clk);
        checkOutput({name, " out_valid done"}, 32'(out_valid), 32'd1);
        checkOutput({name, " out_data"}, 32'(out_data), 32'(expected));
        checkOutput({name, " stage_en done"}, 32'(stage_en), 32'd0);
        checkOutput({name, " busy done"}, 32'(busy), 32'd1);
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput($sformatf("%s held out_valid[%0d]", name, h), 32'(out_valid), 32'd1);
            checkOutput($sformatf("%s held out_data[%0d]", name, h), 32'(out_data), 32'(expected));
            checkOutput($sformatf("%s held in_ready[%0d]", name, h), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, " out_valid after hs"}, 32'(out_valid), 32'd0);
        checkOutput({name, " in_ready after hs"}, 32'(in_ready), 32'd1);
        checkOutput({name, " busy after hs"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h1234, 4'd8,  1'b0, 1'b0, 16'h3400, 0, "left8"};
        vecs[1] = '{16'hA5A5, 4'd0,  1'b0, 1'b0, 16'hA5A5, 0, "left0"};
        vecs[2] = '{16'h0001, 4'd15, 1'b0, 1'b0, 16'h8000, 0, "left15"};
        vecs[3] = '{16'h00FF, 4'd9,  1'b0, 1'b0, 16'hFE00, 0, "left9"};
        vecs[4] = '{16'h8000, 4'd3,  1'b1, 1'b0, 16'h1000, 0, "rlog3"};
        vecs[5] = '{16'h8000, 4'd4,  1'b1, 1'b1, 16'hF800, 3, "rar4neg_bp"};
        vecs[6] = '{16'h8001, 4'd1,  1'b0, 1'b1, 16'h0002, 0, "left1arith"};
        vecs[7] = '{16'h7000, 4'd4,  1'b1, 1'b1, 16'h0700, 0, "rar4pos"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_dir    = 1'b0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset stage_en", 32'(stage_en), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].data, vecs[v].shamt, vecs[v].dir, vecs[v].arith, vecs[v].expected,
                          vecs[v].holdCycles, (v == 2), vecs[v].name);
        end

        // Reset asserted during the k=2 stage discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_shamt = 4'd8;
        in_dir   = 1'b0;
        in_arith = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst stage_en k3", 32'(stage_en), 32'd8);
        @(negedge clk);
        checkOutput("midrst stage_en k2", 32'(stage_en), 32'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst out_data", 32'(out_data), 32'd0);
        checkOutput("midrst stage_en", 32'(stage_en), 32'd0);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < STAGES + 2; c++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst no out_valid[%0d]", c), 32'(out_valid), 32'd0);
        end
        applyStimulus(16'h1234, 4'd8, 1'b0, 1'b0, 16'h3400, 0, 1'b0, "after_rst");

        for (int r = 0; r < 40; r++) begin
            logic [WIDTH-1:0]  rData;
            logic [STAGES-1:0] rShamt;
            logic              rDir;
            logic              rArith;
            rData  = WIDTH'($urandom);
            rShamt = STAGES'($urandom);
            rDir   = 1'($urandom);
            rArith = 1'($urandom);
            applyStimulus(rData, rShamt, rDir, rArith, refShift(rData, rShamt, rDir, rArith),
                          int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
